// File: rtl/cop0_int_dispatch.sv
// cop0_int_dispatch: waits for a precise execute-stage restart point, then
// takes the COP0 interrupt (flush + redirect to handler) or executes ERET.
// Ports: i_clk, i_rst (async, active-high), i_interrupt_request, i_stall,
//   i_exec_valid, i_exec_pc, i_exec_in_delay_slot, i_exec_is_eret, i_epc;
//   o_interrupt_handled, o_interrupted_pc, o_redirect, o_redirect_pc,
//   o_flush, o_in_delay_slot.
// Optional macro COP0_INT_BD_EN: allow takes on delay-slot instructions.
module cop0_int_dispatch #(
  parameter logic [31:0] HANDLER_VECTOR = 32'h0000_0180,
  parameter int unsigned HOLDOFF_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_interrupt_request,
  input  logic        i_stall,
  input  logic        i_exec_valid,
  input  logic [31:0] i_exec_pc,
  input  logic        i_exec_in_delay_slot,
  input  logic        i_exec_is_eret,
  input  logic [31:0] i_epc,
  output logic        o_interrupt_handled,
  output logic [31:0] o_interrupted_pc,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush,
  output logic        o_in_delay_slot
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_TAKE,
    S_ERET,
    S_HOLDOFF
  } state_t;

  localparam logic [3:0] LP_HOLD = HOLDOFF_CYCLES[3:0];

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_handled;
  logic        r_redirect;
  logic        r_flush;
  logic [31:0] r_int_pc;
  logic [31:0] r_redir_pc;

  logic        w_safe;
  logic        w_eret;
  logic        w_open;
  logic        w_do_eret;
  logic        w_do_take;
  logic [31:0] w_take_pc;

  assign w_eret = i_exec_valid & ~i_stall & i_exec_is_eret;

`ifdef COP0_INT_BD_EN
  logic r_bd;

  assign w_safe = i_exec_valid & ~i_stall & ~i_exec_is_eret;
  // Restart at the branch so it re-executes before its delay slot.
  assign w_take_pc = i_exec_in_delay_slot ? i_exec_pc - 32'd4
                                          : i_exec_pc;
  assign o_in_delay_slot = r_bd;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_bd <= 1'b0;
    else
      r_bd <= w_do_take & i_exec_in_delay_slot;
  end
`else
  assign w_safe = i_exec_valid & ~i_stall & ~i_exec_is_eret
                & ~i_exec_in_delay_slot;
  assign w_take_pc = i_exec_pc;
  assign o_in_delay_slot = 1'b0;
`endif

  // Interrupts are only accepted from IDLE/ARMED; ERET also from HOLDOFF.
  assign w_open    = (r_state == S_IDLE) | (r_state == S_ARMED);
  assign w_do_eret = w_eret & (w_open | (r_state == S_HOLDOFF));
  assign w_do_take = ~w_eret & w_open & i_interrupt_request & w_safe;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_handled  <= 1'b0;
      r_redirect <= 1'b0;
      r_flush    <= 1'b0;
      r_int_pc   <= 32'h0;
      r_redir_pc <= 32'h0;
    end else begin
      r_handled  <= w_do_take;
      r_redirect <= w_do_take | w_do_eret;
      r_flush    <= w_do_take | w_do_eret;
      if (w_do_take) begin
        r_int_pc   <= w_take_pc;
        r_redir_pc <= HANDLER_VECTOR;
      end else if (w_do_eret) begin
        r_redir_pc <= i_epc;
      end
      unique case (r_state)
        S_IDLE, S_ARMED: begin
          if (w_do_eret)
            r_state <= S_ERET;
          else if (w_do_take)
            r_state <= S_TAKE;
          else if (i_interrupt_request)
            r_state <= S_ARMED;
          else
            r_state <= S_IDLE;
        end
        S_TAKE, S_ERET: begin
          r_state <= S_HOLDOFF;
          r_cnt   <= LP_HOLD;
        end
        S_HOLDOFF: begin
          if (w_do_eret) begin
            r_state <= S_ERET;
          end else if (r_cnt <= 4'd1) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_interrupt_handled = r_handled;
  assign o_interrupted_pc    = r_int_pc;
  assign o_redirect          = r_redirect;
  assign o_redirect_pc       = r_redir_pc;
  assign o_flush             = r_flush;

endmodule

// File: tb/tb_cop0_int_dispatch.sv
// tb_cop0_int_dispatch: directed + randomized check of cop0_int_dispatch
// against a cycle-level behavioural model of take/ERET/holdoff rules.
module tb_cop0_int_dispatch;

  localparam logic [31:0] HV = 32'h0000_0180;
  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        stall = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        slot = 1'b0;
  logic        is_eret = 1'b0;
  logic [31:0] epc = 32'h0;
  logic        handled, redirect, flush, bd;
  logic [31:0] ipc, rpc;

  int n_checks = 0;
  int n_err = 0;

  // reference model: expected outputs and remaining holdoff cycles
  logic        m_handled, m_redirect, m_flush, m_bd;
  logic [31:0] m_ipc, m_rpc;
  int          m_quiet;

  cop0_int_dispatch #(.HANDLER_VECTOR(HV), .HOLDOFF_CYCLES(HOLD)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_interrupt_request(req),
    .i_stall(stall),
    .i_exec_valid(valid),
    .i_exec_pc(pc),
    .i_exec_in_delay_slot(slot),
    .i_exec_is_eret(is_eret),
    .i_epc(epc),
    .o_interrupt_handled(handled),
    .o_interrupted_pc(ipc),
    .o_redirect(redirect),
    .o_redirect_pc(rpc),
    .o_flush(flush),
    .o_in_delay_slot(bd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".handled"}, {31'h0, handled}, {31'h0, m_handled});
    chk({tag, ".redirect"}, {31'h0, redirect}, {31'h0, m_redirect});
    chk({tag, ".flush"}, {31'h0, flush}, {31'h0, m_flush});
    chk({tag, ".bd"}, {31'h0, bd}, {31'h0, m_bd});
    chk({tag, ".ipc"}, ipc, m_ipc);
    chk({tag, ".rpc"}, rpc, m_rpc);
  endtask

  task automatic model_reset();
    m_handled = 0; m_redirect = 0; m_flush = 0; m_bd = 0;
    m_ipc = 32'h0; m_rpc = 32'h0; m_quiet = 0;
  endtask

  task automatic model_edge();
    bit s_eret, s_safe, in_pulse;
    s_eret = valid && !stall && is_eret;
`ifdef COP0_INT_BD_EN
    s_safe = valid && !stall && !is_eret;
`else
    s_safe = valid && !stall && !is_eret && !slot;
`endif
    in_pulse = m_redirect;
    m_handled = 0; m_redirect = 0; m_flush = 0; m_bd = 0;
    if (in_pulse) begin
      m_quiet = HOLD;
    end else if (s_eret) begin
      m_redirect = 1; m_flush = 1; m_rpc = epc;
    end else if (m_quiet == 0 && req && s_safe) begin
      m_handled = 1; m_redirect = 1; m_flush = 1; m_rpc = HV;
      m_ipc = pc;
`ifdef COP0_INT_BD_EN
      if (slot) begin
        m_ipc = pc - 32'd4;
        m_bd = 1;
      end
`endif
    end else if (m_quiet > 0) begin
      m_quiet--;
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic quiet_inputs();
    req = 0; stall = 0; valid = 0; slot = 0; is_eret = 0;
  endtask

  int takes;

  initial begin
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    step("idle");

    // 1: basic take at a safe point
    req = 1; valid = 1; pc = 32'h0000_1040;
    step("t1.take");
    chk("t1.handled", {31'h0, handled}, 32'h1);
    chk("t1.ipc", ipc, 32'h1040);
    chk("t1.rpc", rpc, 32'h180);
    takes = 0;
    for (int i = 0; i < HOLD + 1; i++) begin
      step("t1.hold");
      takes += int'(handled | redirect | flush);
    end
    chk("t1.no_take_in_holdoff", takes, 0);
    step("t1.retake");
    chk("t1.retake_handled", {31'h0, handled}, 32'h1);
    quiet_inputs();
    for (int i = 0; i < 4; i++) step("gap");

    // 2: stalled request taken one cycle after stall drops
    req = 1; valid = 1; stall = 1; pc = 32'h0000_1100;
    takes = 0;
    for (int i = 0; i < 5; i++) begin
      step("t2.stall");
      takes += int'(handled);
    end
    chk("t2.none_while_stalled", takes, 0);
    stall = 0;
    step("t2.release");
    chk("t2.handled", {31'h0, handled}, 32'h1);
    chk("t2.ipc", ipc, 32'h1100);
    quiet_inputs();
    for (int i = 0; i < 4; i++) step("gap");

    // 3: request on a delay-slot instruction
    req = 1; valid = 1; slot = 1; pc = 32'h0000_2004;
    step("t3.slot");
`ifdef COP0_INT_BD_EN
    chk("t3.handled", {31'h0, handled}, 32'h1);
    chk("t3.ipc", ipc, 32'h2000);
    chk("t3.bd", {31'h0, bd}, 32'h1);
`else
    chk("t3.deferred", {31'h0, handled}, 32'h0);
    slot = 0; pc = 32'h0000_2008;
    step("t3.next");
    chk("t3.handled", {31'h0, handled}, 32'h1);
    chk("t3.ipc", ipc, 32'h2008);
`endif
    quiet_inputs();
    for (int i = 0; i < 4; i++) step("gap");

    // 4: ERET wins over a simultaneous request
    req = 1; valid = 1; is_eret = 1; epc = 32'h0000_3000;
    step("t4.eret");
    chk("t4.redirect", {31'h0, redirect}, 32'h1);
    chk("t4.handled", {31'h0, handled}, 32'h0);
    chk("t4.rpc", rpc, 32'h3000);
    is_eret = 0; pc = 32'h0000_3000;
    takes = 0;
    for (int i = 0; i < HOLD + 1; i++) begin
      step("t4.hold");
      takes += int'(handled);
    end
    chk("t4.no_take_in_holdoff", takes, 0);
    step("t4.after");
    chk("t4.taken_after", {31'h0, handled}, 32'h1);
    quiet_inputs();
    for (int i = 0; i < 4; i++) step("gap");

    // 5: armed request withdrawn before a safe point
    req = 1; valid = 0;
    takes = 0;
    for (int i = 0; i < 3; i++) begin
      step("t5.armed");
      takes += int'(handled | redirect | flush);
    end
    req = 0; valid = 1; pc = 32'h0000_4000;
    for (int i = 0; i < 4; i++) begin
      step("t5.withdrawn");
      takes += int'(handled | redirect | flush);
    end
    chk("t5.no_pulses", takes, 0);
    quiet_inputs();
    for (int i = 0; i < 4; i++) step("gap");

    // 6: asynchronous reset during the take cycle
    req = 1; valid = 1; pc = 32'h0000_5000;
    step("t6.take");
    chk("t6.handled", {31'h0, handled}, 32'h1);
    rst = 1;
    #1;
    model_reset();
    check_all("t6.async");
    chk("t6.ipc_zero", ipc, 32'h0);
    @(posedge clk); #1;
    rst = 0;
    quiet_inputs();
    step("t6.idle");
    req = 1; valid = 1; pc = 32'h0000_5004;
    step("t6.retake");
    chk("t6.retake_handled", {31'h0, handled}, 32'h1);
    quiet_inputs();
    for (int i = 0; i < 4; i++) step("gap");

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      req     = ($urandom_range(0, 3) != 0);
      stall   = ($urandom_range(0, 3) == 0);
      valid   = ($urandom_range(0, 4) != 0);
      slot    = ($urandom_range(0, 4) == 0);
      is_eret = ($urandom_range(0, 9) == 0);
      pc      = $urandom & 32'hFFFF_FFFC;
      epc     = $urandom & 32'hFFFF_FFFC;
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
